// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_arbiter
//  Description : Two-port round-robin arbiter and sequencer for a shared
//                floating-point adder pipeline. Grants at most one request
//                per cycle, registers the winner's operands into the adder
//                issue stage, tracks ownership through a tag pipeline
//                matched to the adder latency, and routes each result back
//                to its requester.
//  Options     : FP_ADD_ARB_FIXED_PRIO_EN - when defined, port 0 always
//                wins a tie (the round-robin pointer is removed).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
  parameter int LATENCY = 3,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_as,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_as,
  input  logic         stall,
  output logic         add_valid,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_as,
  input  logic [W-1:0] add_result,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_data,
  output logic         busy
);

  // The count can reach LATENCY+2 (an op is outstanding from its accept
  // edge until its response pulse ends), so LATENCY+3 states are needed.
  localparam int CNT_W = $clog2(LATENCY + 3);

  logic             winner;     // 0 = port 0, 1 = port 1
  logic             grant_ok;
  logic             accept;
  logic             rsp_fire;
  logic [LATENCY:0] tag_valid;
  logic [LATENCY:0] tag_port;
  logic [CNT_W-1:0] count;

`ifdef FP_ADD_ARB_FIXED_PRIO_EN
  // Fixed priority: port 0 wins whenever it is valid.
  always_comb begin
    winner = !req0_valid;
  end
`else
  logic last;

  // Round-robin: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last;
    end else begin
      winner = req1_valid;
    end
  end

  // Pointer to the most recently granted port; moves only on an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= winner;
    end
  end
`endif

  // Ready is combinational on stall and reset so a stall blocks the same cycle.
  assign grant_ok   = !stall && !reset;
  assign req0_ready = req0_valid && !winner && grant_ok;
  assign req1_ready = req1_valid &&  winner && grant_ok;
  assign accept     = req0_ready || req1_ready;

  // Issue register: capture the winner's operands; hold them when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_as    <= 1'b0;
    end else begin
      add_valid <= accept;
      if (accept) begin
        add_a  <= winner ? req1_a  : req0_a;
        add_b  <= winner ? req1_b  : req0_b;
        add_as <= winner ? req1_as : req0_as;
      end
    end
  end

  // Ownership tags shift alongside the adder; entry LATENCY lines up with add_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      tag_valid <= {tag_valid[LATENCY-1:0], accept};
      tag_port  <= {tag_port[LATENCY-1:0],  winner};
    end
  end

  // Response register: capture the adder output and pulse the owning port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rsp0_valid <= tag_valid[LATENCY] && !tag_port[LATENCY];
      rsp1_valid <= tag_valid[LATENCY] &&  tag_port[LATENCY];
      if (tag_valid[LATENCY]) begin
        rsp_data <= add_result;
      end
    end
  end

  assign rsp_fire = rsp0_valid || rsp1_valid;

  // In-flight count: an op stays counted through the cycle of its response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({accept, rsp_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign busy = (count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_arbiter
//  Description : Self-checking bench for fp_add_arbiter with a queue-based
//                reference model, an adder stand-in, directed stimulus and
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

  localparam int LATENCY = 3;
  localparam int W       = 32;
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_as = 1'b0, req1_as = 1'b0;
  logic         stall = 1'b0;
  logic         add_valid;
  logic [W-1:0] add_a, add_b;
  logic         add_as;
  logic [W-1:0] add_result = '0;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_data;
  logic         busy;

  fp_add_arbiter #(.LATENCY(LATENCY), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_as(req0_as),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_as(req1_as),
    .stall(stall),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_as(add_as),
    .add_result(add_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Adder stand-in: integer add or subtract, chosen by the select bit.
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? (a - b) : (a + b);
  endfunction

  // Adder pipeline: result in cycle c is computed from what was presented in cycle c-LATENCY.
  logic [W-1:0] hist_a  [0:255];
  logic [W-1:0] hist_b  [0:255];
  logic         hist_as [0:255];
  always @(negedge clk) begin
    hist_a[cyc]  = add_a;
    hist_b[cyc]  = add_b;
    hist_as[cyc] = add_as;
    if (cyc > LATENCY) add_result = fadd(hist_a[cyc-LATENCY], hist_b[cyc-LATENCY], hist_as[cyc-LATENCY]);
    else               add_result = '0;
  end

  // Reference model: every accepted op lives in a queue until its response cycle.
  typedef struct {
    logic         port;
    int           acc;
    int           due;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
  } op_t;

  op_t          q[$];
  logic         m_last = 1'b1;
  logic [W-1:0] m_a = '0, m_b = '0, m_rsp = '0;
  logic         m_as = 1'b0;

  int           log_cyc[$];
  int           log_port[$];
  logic [W-1:0] log_data[$];

  // Compare process: check every output every cycle, then advance the model.
  always @(negedge clk) begin : compare
    logic e_issue, e_rsp0, e_rsp1, win, e_r0, e_r1;
    op_t  head;
    op_t  nw;
    if (cyc >= 1) begin
      if (rsp0_valid || rsp1_valid) begin
        log_cyc.push_back(cyc);
        log_port.push_back(rsp1_valid ? 1 : 0);
        log_data.push_back(rsp_data);
      end
      e_issue = (q.size() > 0) && (q[q.size()-1].acc == cyc - 1);
      chk("add_valid", add_valid, e_issue);
      chk("add_a", add_a, m_a);
      chk("add_b", add_b, m_b);
      chk("add_as", add_as, m_as);
      chk("busy", busy, q.size() != 0);
      e_rsp0 = 1'b0;
      e_rsp1 = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        head   = q.pop_front();
        e_rsp0 = (head.port == 1'b0);
        e_rsp1 = (head.port == 1'b1);
        m_rsp  = fadd(head.a, head.b, head.sub);
      end
      chk("rsp0_valid", rsp0_valid, e_rsp0);
      chk("rsp1_valid", rsp1_valid, e_rsp1);
      chk("rsp_data", rsp_data, m_rsp);
      if (req0_valid && req1_valid) win = FIXED ? 1'b0 : ~m_last;
      else                          win = ~req0_valid;
      e_r0 = !reset && !stall && req0_valid && !win;
      e_r1 = !reset && !stall && req1_valid &&  win;
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      if (reset) begin
        q.delete();
        m_last = 1'b1;
        m_a = '0; m_b = '0; m_as = 1'b0; m_rsp = '0;
      end else if (e_r0 || e_r1) begin
        nw.port = win;
        nw.acc  = cyc;
        nw.due  = cyc + LATENCY + 2;
        nw.a    = win ? req1_a  : req0_a;
        nw.b    = win ? req1_b  : req0_b;
        nw.sub  = win ? req1_as : req0_as;
        q.push_back(nw);
        m_last = win;
        m_a = nw.a; m_b = nw.b; m_as = nw.sub;
      end
    end
  end

  // Advance to just after the edge that starts cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int exp_lc[13] = '{10, 18, 25, 26, 27, 28, 29, 30, 41, 45, 46, 47, 65};
  int exp_lp_rr[13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0};
  int exp_lp_fx[13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    goto(3);
    reset = 1'b0;

    // Single request on port 0
    goto(5);
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_as = 1'b0;
    goto(6);
    req0_valid = 1'b0;

    // Subtract passthrough on port 1
    goto(13);
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_as = 1'b1;
    goto(14);
    req1_valid = 1'b0;
    chk("issue_valid_c14", add_valid, 1'b1);
    chk("issue_as_c14", add_as, 1'b1);
    chk("issue_a_c14", add_a, 32'h40400000);

    // Contention: both valid for 6 cycles with fresh operands each cycle
    req1_as = 1'b0;
    for (int i = 0; i < 6; i++) begin
      goto(20 + i);
      req0_valid = 1'b1; req0_a = 32'h1000 + i; req0_b = 32'h10;
      req1_valid = 1'b1; req1_a = 32'h2000 + i; req1_b = 32'h20;
    end
    goto(26);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Stall with both valid, then release
    goto(32);
    req0_valid = 1'b1; req1_valid = 1'b1; stall = 1'b1;
    #1;
    chk("stall_r0_c32", req0_ready, 1'b0);
    chk("stall_r1_c32", req1_ready, 1'b0);
    goto(36);
    stall = 1'b0;
    #1;
    chk("release_r0_c36", req0_ready, 1'b1);
    goto(37);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Drain under stall
    goto(40);
    req0_valid = 1'b1; req1_valid = 1'b0;
    goto(41);
    req0_valid = 1'b0; req1_valid = 1'b1;
    goto(42);
    req0_valid = 1'b1; req1_valid = 1'b0;
    goto(43);
    req0_valid = 1'b1; req1_valid = 1'b1; stall = 1'b1;
    goto(47);
    chk("drain_busy_c47", busy, 1'b1);
    goto(48);
    chk("drain_busy_c48", busy, 1'b0);
    goto(51);
    req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0;

    // Reset mid-flight
    goto(55);
    req0_valid = 1'b1;
    goto(56);
    req0_valid = 1'b0; req1_valid = 1'b1;
    goto(57);
    req1_valid = 1'b0;
    goto(58);
    reset = 1'b1;
    goto(59);
    reset = 1'b0;
    chk("post_reset_busy_c59", busy, 1'b0);
    goto(60);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_reset_tie_c60", req0_ready, 1'b1);
    goto(61);
    req0_valid = 1'b0; req1_valid = 1'b0;

    goto(72);

    // Literal response log: cycle, port and selected data values
    chk("log_count", log_cyc.size(), 13);
    for (int i = 0; i < 13 && i < log_cyc.size(); i++) begin
      chk($sformatf("log_cycle_%0d", i), log_cyc[i], exp_lc[i]);
      chk($sformatf("log_port_%0d", i), log_port[i], FIXED ? exp_lp_fx[i] : exp_lp_rr[i]);
    end
    if (log_data.size() >= 4) begin
      chk("log_data_0", log_data[0], 32'h7F800000);
      chk("log_data_1", log_data[1], 32'h00C00000);
      chk("log_data_2", log_data[2], 32'h00001010);
      chk("log_data_3", log_data[3], FIXED ? 32'h00001011 : 32'h00002021);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
